// File: rtl/param_entry_ctrl.sv
// Front-panel operand entry and launch controller for the Simpson's-rule integrator.
// Optional auto-repeat on up/down buttons is enabled by defining PARAM_ENTRY_AUTOREPEAT_EN.
//
// state | meaning
// EDIT  | panel live: buttons edit a/b/n, start press validates and launches
// RUN   | integrator busy: operands frozen, button events dropped until done
module param_entry_ctrl #(
    parameter int WIDTH         = 8,
    parameter int DEB_CYCLES    = 4,
    parameter int REPEAT_CYCLES = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_up,
    input  logic             btn_down,
    input  logic             btn_next,
    input  logic             btn_start,
    input  logic             done,
    output logic [WIDTH-1:0] a_val,
    output logic [WIDTH-1:0] b_val,
    output logic [WIDTH-1:0] n_val,
    output logic [1:0]       field,
    output logic             start,
    output logic             ready,
    output logic             err
);
    localparam int            CW       = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] DEB_FULL = CW'(DEB_CYCLES);
    localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);

    typedef enum logic {EDIT, RUN} state_t;
    state_t state;

    logic [3:0]    raw;
    logic [3:0]    press;
    logic [3:0]    ev;
    logic [CW-1:0] deb_cnt [4];

    assign raw = {btn_start, btn_next, btn_down, btn_up};

    // Counter parks at DEB_FULL while held so a hold yields exactly one press.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) deb_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (!raw[i])
                    deb_cnt[i] <= '0;
                else if (deb_cnt[i] != DEB_FULL)
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
            end
        end
    end

    always_comb begin
        press = '0;
        for (int i = 0; i < 4; i++) press[i] = raw[i] && (deb_cnt[i] == DEB_LAST);
    end

`ifdef PARAM_ENTRY_AUTOREPEAT_EN
    localparam int            RW     = $clog2(REPEAT_CYCLES + 1);
    localparam logic [RW-1:0] RELOAD = RW'(REPEAT_CYCLES - 1);

    logic [RW-1:0] rep_cnt [2];
    logic [1:0]    rep;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) rep_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (press[i])
                    rep_cnt[i] <= RELOAD;
                else if (raw[i] && deb_cnt[i] == DEB_FULL)
                    rep_cnt[i] <= (rep_cnt[i] == '0) ? RELOAD : rep_cnt[i] - 1'b1;
            end
        end
    end

    always_comb begin
        rep = '0;
        for (int i = 0; i < 2; i++)
            rep[i] = raw[i] && (deb_cnt[i] == DEB_FULL) && (rep_cnt[i] == '0);
    end

    assign ev = {press[3:2], press[1:0] | rep};
`else
    assign ev = press;
`endif

    function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] v, input logic inc);
        if (inc) return (v == '1) ? v : v + 1'b1;
        else     return (v == '0) ? v : v - 1'b1;
    endfunction

    logic operands_ok;
    assign operands_ok = (a_val < b_val) && (n_val >= WIDTH'(2)) && !n_val[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EDIT;
            a_val <= WIDTH'(0);
            b_val <= WIDTH'(1);
            n_val <= WIDTH'(2);
            field <= 2'd0;
            start <= 1'b0;
            ready <= 1'b1;
            err   <= 1'b0;
        end else begin
            start <= 1'b0;
            case (state)
                EDIT: begin
                    if (ev[3]) begin
                        if (operands_ok) begin
                            start <= 1'b1;
                            err   <= 1'b0;
                            ready <= 1'b0;
                            state <= RUN;
                        end else begin
                            err <= 1'b1;
                        end
                    end else if (ev[2]) begin
                        field <= (field == 2'd2) ? 2'd0 : field + 2'd1;
                        err   <= 1'b0;
                    end else if (ev[0] || ev[1]) begin
                        case (field)
                            2'd0:    a_val <= step(a_val, ev[0]);
                            2'd1:    b_val <= step(b_val, ev[0]);
                            default: n_val <= step(n_val, ev[0]);
                        endcase
                        err <= 1'b0;
                    end
                end
                RUN: begin
                    if (done) begin
                        state <= EDIT;
                        ready <= 1'b1;
                    end
                end
                default: state <= EDIT;
            endcase
        end
    end
endmodule

// File: tb/tb_param_entry_ctrl.sv
// Scoreboard bench for param_entry_ctrl: stimulus queues expected output changes with their
// cycle, a negedge monitor pops one entry per observed change.
module tb_param_entry_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] btn = 4'b0;   // {start, next, down, up}
    logic       done = 1'b0;
    logic [7:0] a_val, b_val, n_val;
    logic [1:0] field;
    logic       start, ready, err;

    param_entry_ctrl #(.WIDTH(8), .DEB_CYCLES(4), .REPEAT_CYCLES(64)) dut (
        .clk(clk), .rst(rst),
        .btn_up(btn[0]), .btn_down(btn[1]), .btn_next(btn[2]), .btn_start(btn[3]),
        .done(done),
        .a_val(a_val), .b_val(b_val), .n_val(n_val),
        .field(field), .start(start), .ready(ready), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [28:0] val;
    } exp_t;

    exp_t        q[$];
    int          cyc = 0;
    int          compared = 0;
    int          mismatched = 0;
    logic        mon_en = 1'b0;
    logic [28:0] prev = '0;
    logic [28:0] cur;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        exp_t e;
        cur = {a_val, b_val, n_val, field, start, ready, err};
        if (mon_en && cur !== prev) begin
            compared++;
            if (q.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected_change cyc=%0d got a=%0d b=%0d n=%0d f=%0d st=%b rdy=%b err=%b",
                         cyc, a_val, b_val, n_val, field, start, ready, err);
            end else begin
                e = q.pop_front();
                if (e.cyc != cyc || e.val !== cur) begin
                    mismatched++;
                    $display("FAIL change cyc=%0d got %h, required cyc=%0d val %h (a,b,n,f,st,rdy,err)",
                             cyc, cur, e.cyc, e.val);
                end
            end
        end
        prev = cur;
    end

    task automatic exp_at(input int c, input logic [7:0] ea, input logic [7:0] eb,
                          input logic [7:0] en, input logic [1:0] ef,
                          input logic es, input logic er, input logic ee);
        exp_t e;
        e.cyc = c;
        e.val = {ea, eb, en, ef, es, er, ee};
        q.push_back(e);
    endtask

    // Called at a negedge; holds button idx high for n sampling edges then releases.
    task automatic hold_btn(input int idx, input int n);
        btn[idx] = 1'b1;
        repeat (n) @(negedge clk);
        btn[idx] = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int c;
        repeat (3) @(negedge clk);
        compared++;
        if ({a_val, b_val, n_val, field, start, ready, err} !== {8'd0, 8'd1, 8'd2, 2'd0, 1'b0, 1'b1, 1'b0}) begin
            mismatched++;
            $display("FAIL reset_values got a=%0d b=%0d n=%0d f=%0d st=%b rdy=%b err=%b, required 0 1 2 0 0 1 0",
                     a_val, b_val, n_val, field, start, ready, err);
        end
        rst = 1'b0;
        mon_en = 1'b1;
        idle(2);

        // Glitch of 3 samples: no event
        hold_btn(0, 3);
        idle(3);

        // Valid start from reset operands
        c = cyc;
        exp_at(c + 4, 0, 1, 2, 0, 1, 0, 0);
        exp_at(c + 5, 0, 1, 2, 0, 0, 0, 0);
        hold_btn(3, 4);
        idle(2);
        // Down press during RUN is discarded
        hold_btn(1, 6);
        idle(2);
        c = cyc;
        exp_at(c + 1, 0, 1, 2, 0, 0, 1, 0);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        idle(2);
        // done in EDIT ignored
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        idle(2);

        // Back-to-back run: start qualifies the edge right after done
        c = cyc;
        exp_at(c + 4, 0, 1, 2, 0, 1, 0, 0);
        exp_at(c + 5, 0, 1, 2, 0, 0, 0, 0);
        hold_btn(3, 4);
        idle(2);
        c = cyc;
        exp_at(c + 3, 0, 1, 2, 0, 0, 1, 0);
        exp_at(c + 4, 0, 1, 2, 0, 1, 0, 0);
        exp_at(c + 5, 0, 1, 2, 0, 0, 0, 0);
        btn[3] = 1'b1;
        idle(2);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        @(negedge clk);
        btn[3] = 1'b0;
        idle(2);
        // done and an up event on the same RUN edge: only the return to EDIT
        c = cyc;
        exp_at(c + 4, 0, 1, 2, 0, 0, 1, 0);
        btn[0] = 1'b1;
        idle(3);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        btn[0] = 1'b0;
        idle(2);

        // Long hold on up: one event, or a repeat at press+64 with auto-repeat
        c = cyc;
        exp_at(c + 4, 1, 1, 2, 0, 0, 1, 0);
`ifdef PARAM_ENTRY_AUTOREPEAT_EN
        exp_at(c + 68, 2, 1, 2, 0, 0, 1, 0);
`endif
        hold_btn(0, 104);
        idle(2);
`ifdef PARAM_ENTRY_AUTOREPEAT_EN
        c = cyc;
        exp_at(c + 4, 1, 1, 2, 0, 0, 1, 0);
        hold_btn(1, 4);
        idle(2);
`endif

        // next, next, up -> field 2, n 3; start rejected; up -> n 4 clears err
        c = cyc; exp_at(c + 4, 1, 1, 2, 1, 0, 1, 0); hold_btn(2, 4); idle(2);
        c = cyc; exp_at(c + 4, 1, 1, 2, 2, 0, 1, 0); hold_btn(2, 4); idle(2);
        c = cyc; exp_at(c + 4, 1, 1, 3, 2, 0, 1, 0); hold_btn(0, 4); idle(2);
        c = cyc; exp_at(c + 4, 1, 1, 3, 2, 0, 1, 1); hold_btn(3, 4); idle(2);
        c = cyc; exp_at(c + 4, 1, 1, 4, 2, 0, 1, 0); hold_btn(0, 4); idle(2);

        // up and next qualify together: only field moves (2 -> 0)
        c = cyc;
        exp_at(c + 4, 1, 1, 4, 0, 0, 1, 0);
        btn[0] = 1'b1; btn[2] = 1'b1;
        idle(4);
        btn[0] = 1'b0; btn[2] = 1'b0;
        idle(2);

        // a -> 5, then b -> 6
        for (int i = 2; i <= 5; i++) begin
            c = cyc; exp_at(c + 4, i[7:0], 1, 4, 0, 0, 1, 0); hold_btn(0, 4); idle(2);
        end
        c = cyc; exp_at(c + 4, 5, 1, 4, 1, 0, 1, 0); hold_btn(2, 4); idle(2);
        for (int i = 2; i <= 6; i++) begin
            c = cyc; exp_at(c + 4, 5, i[7:0], 4, 1, 0, 1, 0); hold_btn(0, 4); idle(2);
        end
        c = cyc;
        exp_at(c + 4, 5, 6, 4, 1, 1, 0, 0);
        exp_at(c + 5, 5, 6, 4, 1, 0, 0, 0);
        hold_btn(3, 4);
        idle(2);

        // Reset during RUN with up held through it
        c = cyc;
        exp_at(c + 1, 0, 1, 2, 0, 0, 1, 0);
        exp_at(c + 5, 1, 1, 2, 0, 0, 1, 0);
        rst = 1'b1; btn[0] = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        idle(4);
        btn[0] = 1'b0;
        idle(2);

        // Down saturates at 0
        c = cyc; exp_at(c + 4, 0, 1, 2, 0, 0, 1, 0); hold_btn(1, 4); idle(2);
        hold_btn(1, 4);
        idle(4);

        compared++;
        if (q.size() != 0) begin
            mismatched++;
            $display("FAIL pending_expected got %0d unmatched entries, required 0 (next cyc=%0d)",
                     q.size(), q[0].cyc);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/param_entry_ctrl.md
# param_entry_ctrl

Front-panel controller for the Simpson's-rule integrator. It debounces four raw push-buttons and turns them into single press events. Those events edit three operand registers: lower bound `a`, upper bound `b` and interval count `n`. On a start press it validates the operands, launches the integrator with a one-cycle `start` pulse, and locks the panel until the integrator reports `done`.

## Interface
Parameters:
- `WIDTH`, 8: width of each operand register.
- `DEB_CYCLES`, 4: consecutive high samples that qualify a press (≥2).
- `REPEAT_CYCLES`, 64: auto-repeat interval in cycles (used only with the macro).

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `btn_up` in 1: raw button; increments the selected field.
- `btn_down` in 1: raw button; decrements the selected field.
- `btn_next` in 1: raw button; selects the next field.
- `btn_start` in 1: raw button; validates operands and launches the run.
- `done` in 1: integrator finished; sampled only in RUN.
- `a_val` out WIDTH: operand `a`.
- `b_val` out WIDTH: operand `b`.
- `n_val` out WIDTH: operand `n`.
- `field` out 2: selected field; 0 = a, 1 = b, 2 = n (3 never occurs).
- `start` out 1: one-cycle launch pulse.
- `ready` out 1: high in EDIT, low in RUN.
- `err` out 1: last start press was rejected.

## Operation
- Debounce, per button:
  - Counter increments on each edge the raw input is high.
  - A raw low on any edge clears the counter and re-arms the button.
  - The edge of the DEB_CYCLES-th consecutive high sample produces one press event.
  - No further events until the button is released, except auto-repeat (see Configuration).
- Same-edge events: priority start > next > up > down; lower-priority events that edge are discarded, not queued.
- FSM EDIT:
  - next: `field` steps 0 → 1 → 2 → 0.
  - up: selected register +1, saturating at 2^WIDTH-1.
  - down: selected register -1, saturating at 0.
  - Any up, down or next event clears `err`.
  - start with valid operands (a < b, n ≥ 2, n even): `start` = 1 for one cycle, `err` = 0, `ready` = 0, go to RUN.
  - start with invalid operands: `err` = 1, stay in EDIT, no pulse.
- FSM RUN:
  - Operand registers frozen; all button events discarded, though debounce counters keep running.
  - `done` = 1 on an edge: go to EDIT, `ready` = 1.
  - `done` while in EDIT is ignored.
- Reset values:
  - a = 0, b = 1, n = 2.
  - `field` = 0, `start` = 0, `ready` = 1, `err` = 0.
  - Debounce counters 0, state EDIT.
  - Reset in RUN aborts to EDIT.
  - A button held through reset yields a press DEB_CYCLES edges after reset deasserts.

## Timing
- Press latency: an action's register update is visible after the edge of the DEB_CYCLES-th consecutive high sample.
- `start` goes high on that same edge and is low on the next edge.
- `ready` falls on the same edge that `start` rises.
- `done` sampled high on edge k: `ready` = 1 after edge k.
- A start press on edge k+1 is honoured, so back-to-back runs are possible.
- `done` and a button event on the same RUN edge: the transition to EDIT happens and the event is discarded.
- A glitch shorter than DEB_CYCLES samples produces no event.

## Configuration
- `PARAM_ENTRY_AUTOREPEAT_EN` defined:
  - While `btn_up` or `btn_down` stays high after its press, a further event fires every REPEAT_CYCLES edges.
  - The first repeat fires REPEAT_CYCLES edges after the press edge.
  - Repeats stop on release.
  - `btn_next` and `btn_start` never repeat.
- Undefined: exactly one event per hold for all buttons, and the repeat counter is not instantiated.

## Test plan
- Reset, hold `btn_up` 3 cycles then release (DEB_CYCLES = 4) -> `a_val` stays 0, no event.
- Hold `btn_up` 4 cycles -> `a_val` 0 → 1 on the 4th edge; holding 100 more cycles leaves it at 1 (macro off), or gives 2 at press+64 (macro on).
- From reset, press `btn_start` -> valid (0 < 1, n = 2): `start` high exactly one cycle, `ready` low; assert `done` -> `ready` high next edge.
- Press `btn_next`, `btn_next`, then `btn_up` -> `field` = 2, n = 3; press start -> `err` = 1, no pulse; press `btn_up` -> n = 4, `err` = 0.
- `btn_up` and `btn_next` qualify on the same edge -> only `field` increments; `a_val` unchanged. In RUN, a press of `btn_down` leaves all operands unchanged.
- Assert `rst` in RUN with a = 5 -> all outputs return to reset values after the edge; a held `btn_up` then increments `a` to 1 four edges after reset deasserts.
